// File: rtl/pwm_led_sequencer.sv
// 8-channel LED PWM sequencer: free-running PWM counter, per-LED duty registers,
// and a slow step timer driving sweep / fade / static / off patterns.
module pwm_led_sequencer #(
    parameter int unsigned PWM_BITS     = 4,
    parameter int unsigned STEP_PERIODS = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pwm_enable,
    input  logic [1:0] i_mode,
    output logic [7:0] o_leds,
    output logic       o_step_strobe,
    output logic [2:0] o_pos
);
    localparam int unsigned STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [PWM_BITS-1:0] DMAX      = {PWM_BITS{1'b1}};
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);

    localparam logic [1:0] MODE_SWEEP  = 2'd0;
    localparam logic [1:0] MODE_FADE   = 2'd1;
    localparam logic [1:0] MODE_STATIC = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [STEP_W-1:0]   r_step_cnt;
    logic [2:0]          r_pos;
    logic                r_dir;        // 0 = up, 1 = down
    logic [PWM_BITS-1:0] r_level;
    logic                r_level_dir;  // 0 = up, 1 = down
    logic [PWM_BITS-1:0] r_duty [8];
    logic [7:0]          r_leds;
    logic                r_step_strobe;
    logic [1:0]          r_mode_q;
    logic                r_entry_pend;

    logic                w_period_tick;
    logic                w_step_tick;
    logic                w_entry;
    logic [2:0]          w_pos_next;
    logic                w_dir_next;
    logic [PWM_BITS-1:0] w_level_next;
    logic                w_level_dir_next;
    logic [PWM_BITS-1:0] w_duty_next [8];
    logic [7:0]          w_leds_next;

    // r_entry_pend forces the mode-entry init after reset even if mode matches r_mode_q.
    always_comb begin
        w_period_tick = i_pwm_enable && (r_pwm_cnt == DMAX);
        w_step_tick   = w_period_tick && (r_step_cnt == STEP_LAST);
        w_entry       = i_pwm_enable && ((i_mode != r_mode_q) || r_entry_pend);

        w_pos_next = r_pos;
        w_dir_next = r_dir;
        if (!r_dir) begin
            if (r_pos == 3'd7) begin
                w_pos_next = 3'd6;
                w_dir_next = 1'b1;
            end else begin
                w_pos_next = r_pos + 3'd1;
            end
        end else begin
            if (r_pos == 3'd0) begin
                w_pos_next = 3'd1;
                w_dir_next = 1'b0;
            end else begin
                w_pos_next = r_pos - 3'd1;
            end
        end

        w_level_next     = r_level;
        w_level_dir_next = r_level_dir;
        if (!r_level_dir) begin
            if (r_level == DMAX) begin
                w_level_next     = DMAX - PWM_BITS'(1);
                w_level_dir_next = 1'b1;
            end else begin
                w_level_next = r_level + PWM_BITS'(1);
            end
        end else begin
            if (r_level == '0) begin
                w_level_next     = PWM_BITS'(1);
                w_level_dir_next = 1'b0;
            end else begin
                w_level_next = r_level - PWM_BITS'(1);
            end
        end
    end

    always_comb begin
        w_duty_next = r_duty;
        if (w_entry) begin
            case (i_mode)
                MODE_SWEEP: begin
                    for (int i = 0; i < 8; i++) w_duty_next[i] = '0;
                    w_duty_next[0] = DMAX;
                end
                MODE_STATIC: for (int i = 0; i < 8; i++) w_duty_next[i] = DMAX;
                MODE_FADE,
                MODE_OFF:    for (int i = 0; i < 8; i++) w_duty_next[i] = '0;
                default:     for (int i = 0; i < 8; i++) w_duty_next[i] = '0;
            endcase
        end else if (w_step_tick) begin
            if (r_mode_q == MODE_SWEEP) begin
                for (int i = 0; i < 8; i++) w_duty_next[i] = r_duty[i] >> 1;
                w_duty_next[w_pos_next] = DMAX;
            end else if (r_mode_q == MODE_FADE) begin
                for (int i = 0; i < 8; i++) w_duty_next[i] = w_level_next;
            end
        end

        for (int i = 0; i < 8; i++) begin
            w_leds_next[i] = i_pwm_enable && (r_duty[i] > r_pwm_cnt);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pwm_cnt     <= '0;
            r_step_cnt    <= '0;
            r_pos         <= '0;
            r_dir         <= 1'b0;
            r_level       <= '0;
            r_level_dir   <= 1'b0;
            r_leds        <= '0;
            r_step_strobe <= 1'b0;
            r_mode_q      <= MODE_SWEEP;
            r_entry_pend  <= 1'b1;
            for (int i = 0; i < 8; i++) r_duty[i] <= '0;
        end else begin
            r_leds        <= w_leds_next;
            r_step_strobe <= w_step_tick && !w_entry;
            r_duty        <= w_duty_next;
            if (!i_pwm_enable) begin
                r_pwm_cnt <= '0;
            end else begin
                r_pwm_cnt    <= r_pwm_cnt + PWM_BITS'(1);
                r_entry_pend <= 1'b0;
                if (w_entry) begin
                    r_mode_q    <= i_mode;
                    r_step_cnt  <= '0;
                    r_pos       <= '0;
                    r_dir       <= 1'b0;
                    r_level     <= '0;
                    r_level_dir <= 1'b0;
                end else begin
                    if (w_period_tick) begin
                        r_step_cnt <= (r_step_cnt == STEP_LAST) ? '0 : r_step_cnt + STEP_W'(1);
                    end
                    if (w_step_tick && (r_mode_q == MODE_SWEEP)) begin
                        r_pos <= w_pos_next;
                        r_dir <= w_dir_next;
                    end
                    if (w_step_tick && (r_mode_q == MODE_FADE)) begin
                        r_level     <= w_level_next;
                        r_level_dir <= w_level_dir_next;
                    end
                end
            end
        end
    end

    assign o_leds        = r_leds;
    assign o_step_strobe = r_step_strobe;
    assign o_pos         = r_pos;

endmodule

// File: tb/tb_pwm_led_sequencer.sv
// Bench for pwm_led_sequencer (PWM_BITS=4, STEP_PERIODS=2): directed stimulus, strobe
// scoreboard checked by a separate monitor, plus duty-window measurements on the LEDs.
module tb_pwm_led_sequencer;
    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       pwm_enable = 1'b1;
    logic [1:0] mode       = 2'd2;
    logic [7:0] leds;
    logic       step_strobe;
    logic [2:0] pos;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int mark_cyc = 0;
    int prev_cyc = 0;
    bit armed    = 1'b0;

    typedef struct {
        int pos;
        int gap;
        bit from_mark;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int sweep_pos [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int fade_exp  [31] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                           14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    pwm_led_sequencer #(
        .PWM_BITS     (4),
        .STEP_PERIODS (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pwm_enable  (pwm_enable),
        .i_mode        (mode),
        .o_leds        (leds),
        .o_step_strobe (step_strobe),
        .o_pos         (pos)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int p, input int gap, input bit from_mark);
        exp_t e;
        e.pos       = p;
        e.gap       = gap;
        e.from_mark = from_mark;
        sb_q.push_back(e);
    endtask

    // Returns just past the negedge on which a strobe is seen.
    task automatic wait_strobe(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (step_strobe) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: got no strobe within 80 cycles, required one", name);
        end
        #1;
    endtask

    task automatic window(output int c0, output int c1, output int others, output int all_eq);
        c0     = 0;
        c1     = 0;
        others = 0;
        all_eq = 1;
        repeat (16) begin
            @(negedge clk);
            c0 += int'(leds[0]);
            c1 += int'(leds[1]);
            others |= int'(leds[7:1]);
            if (leds != {8{leds[0]}}) all_eq = 0;
        end
    endtask

    // Monitor: every strobe while armed must match the head of the scoreboard.
    always @(negedge clk) begin
        if (step_strobe) begin
            if (armed) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got strobe at cycle %0d, required none", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("strobe_pos", int'(pos), mon_e.pos);
                    check("strobe_gap", cyc - (mon_e.from_mark ? mark_cyc : prev_cyc), mon_e.gap);
                end
            end
            prev_cyc = cyc;
        end
    end

    initial begin
        int c0, c1, oth, eq, nz, ff_cnt, zero_cnt, seen;

        // Reset, then static-full entry
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_leds", int'(leds), 0);
        check("reset_strobe", int'(step_strobe), 0);
        check("reset_pos", int'(pos), 0);
        rst = 1'b0;
        @(negedge clk);
        ff_cnt   = 0;
        zero_cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (leds == 8'hFF) ff_cnt++;
            if (leds == 8'h00) zero_cnt++;
        end
        check("static_on_cycles", ff_cnt, 15);
        check("static_off_cycles", zero_cnt, 1);
        wait_strobe("static_sync");

        // Sweep
        mode     = 2'd0;
        mark_cyc = cyc;
        armed    = 1'b1;
        for (int k = 0; k < 15; k++) push_exp(sweep_pos[k], 32, k == 0);
        repeat (2) @(negedge clk);
        window(c0, c1, oth, eq);
        check("sweep_init_led0", c0, 15);
        check("sweep_init_others", oth, 0);
        wait_strobe("sweep_step1");
        window(c0, c1, oth, eq);
        check("sweep_step1_led0", c0, 7);
        check("sweep_step1_led1", c1, 15);
        repeat (14) wait_strobe("sweep_walk");
        push_exp(2, 32, 1'b0);
        push_exp(3, 32, 1'b0);
        repeat (2) wait_strobe("sweep_to_pos3");

        // Enable drop mid-step at pos 3
        repeat (20) @(negedge clk);
        pwm_enable = 1'b0;
        nz = 0;
        repeat (50) begin
            @(negedge clk);
            nz |= int'(leds);
        end
        check("disable_leds", nz, 0);
        check("disable_pos", int'(pos), 3);
        pwm_enable = 1'b1;
        mark_cyc   = cyc;
        push_exp(4, 16, 1'b1);
        wait_strobe("resume_step");
        push_exp(5, 32, 1'b0);
        wait_strobe("sweep_pos5");

        // Reset mid-sweep at pos 5
        rst = 1'b1;
        @(negedge clk);
        check("midrst_leds", int'(leds), 0);
        check("midrst_pos", int'(pos), 0);
        check("midrst_strobe", int'(step_strobe), 0);
        rst      = 1'b0;
        mark_cyc = cyc;
        push_exp(1, 32, 1'b1);
        repeat (2) @(negedge clk);
        check("midrst_entry_leds", int'(leds), 8'h01);
        wait_strobe("post_reset_step");

        // Mode change coincident with step tick, then fade
        repeat (31) @(negedge clk);
        mode = 2'd1;
        @(negedge clk);
        check("modechg_no_strobe", int'(step_strobe), 0);
        check("modechg_pos", int'(pos), 0);
        #1;
        mark_cyc = cyc;
        for (int k = 0; k < 31; k++) push_exp(0, 32, k == 0);
        @(negedge clk);
        check("fade_entry_leds", int'(leds), 0);
        for (int k = 0; k < 31; k++) begin
            wait_strobe("fade_step");
            window(c0, c1, oth, eq);
            check("fade_level", c0, fade_exp[k]);
            check("fade_uniform", eq, 1);
        end

        // Off: dark while strobes continue
        mode     = 2'd3;
        mark_cyc = cyc;
        push_exp(0, 32, 1'b1);
        push_exp(0, 32, 1'b0);
        seen = 0;
        nz   = 0;
        for (int i = 0; i < 100 && seen < 2; i++) begin
            @(negedge clk);
            if (i >= 2) nz |= int'(leds);
            if (step_strobe) seen++;
        end
        check("off_strobes", seen, 2);
        check("off_leds", nz, 0);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
